button_event_decoder: RTL and testbench

- Consumes the debounced, registered push-button level produced upstream and turns it into single-cycle gesture events: press, release, click, double-click and long-press.
- Also keeps a running count of completed clicks.
- Runs on the same ~100 Hz tick clock as the debouncer and feeds the UI/control FSMs, so they never have to poll levels.

---
 rtl/button_event_decoder_if.sv | 20 ++
 rtl/button_event_decoder.sv | 120 ++++++++++++
 tb/tb_button_event_decoder.sv | 96 +++++++++
 3 files changed

// File: rtl/button_event_decoder_if.sv
// button_event_decoder_if: debounced button level in, gesture events and click count out.
interface button_event_decoder_if;
  logic       pb_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       click;
  logic       double_click;
  logic       long_press;
  logic       repeat_pulse;
  logic       held;
  logic [7:0] evt_count;
  modport master (
    output pb_level,
    input  press_pulse, release_pulse, click, double_click, long_press, repeat_pulse, held, evt_count
  );
  modport slave (
    input  pb_level,
    output press_pulse, release_pulse, click, double_click, long_press, repeat_pulse, held, evt_count
  );
endinterface

// File: rtl/button_event_decoder.sv
// button_event_decoder: turns a debounced button level into press/release/click/double-click/long-press pulses.
// Optional auto-repeat while held in LONG is enabled by defining BUTTON_AUTOREPEAT_EN.
module button_event_decoder #(
  parameter int LONG_TICKS   = 100,
  parameter int DCLICK_TICKS = 30,
  parameter int REPEAT_TICKS = 20,
  parameter int CNT_W        = 8
) (
  input logic clk,
  input logic rst_n,
  button_event_decoder_if.slave bus
);
  typedef enum logic [2:0] {LOCK, IDLE, PRESS1, WAIT2, PRESS2, LONG} state_t;
  localparam logic [CNT_W-1:0] LONG_END   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DCLICK_END = CNT_W'(DCLICK_TICKS - 1);
  if (LONG_TICKS > 2**CNT_W || DCLICK_TICKS > 2**CNT_W || REPEAT_TICKS > 2**CNT_W) begin : g_bad_cnt_w
    $error("CNT_W too narrow for tick parameters");
  end
  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [7:0]       evt_count;
  logic             pb, press_pulse, release_pulse, click, double_click, long_press, held;
  assign pb = bus.pb_level;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= LOCK;
      timer         <= '0;
      evt_count     <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click         <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
      held          <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click         <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
      // level is tested before the timer so a coincident edge wins over the threshold
      case (state)
        LOCK: if (!pb) state <= IDLE;
        IDLE: if (pb) begin
          state       <= PRESS1;
          timer       <= '0;
          press_pulse <= 1'b1;
          held        <= 1'b1;
        end
        PRESS1: if (!pb) begin
          state         <= WAIT2;
          timer         <= '0;
          release_pulse <= 1'b1;
          held          <= 1'b0;
        end else if (timer == LONG_END) begin
          state      <= LONG;
          long_press <= 1'b1;
        end else timer <= timer + CNT_W'(1);
        WAIT2: if (pb) begin
          state       <= PRESS2;
          timer       <= '0;
          press_pulse <= 1'b1;
          held        <= 1'b1;
        end else if (timer == DCLICK_END) begin
          state     <= IDLE;
          click     <= 1'b1;
          evt_count <= evt_count + 8'd1;
        end else timer <= timer + CNT_W'(1);
        PRESS2: if (!pb) begin
          state         <= IDLE;
          release_pulse <= 1'b1;
          double_click  <= 1'b1;
          evt_count     <= evt_count + 8'd1;
          held          <= 1'b0;
        end else if (timer == LONG_END) begin
          state      <= LONG;
          long_press <= 1'b1;
        end else timer <= timer + CNT_W'(1);
        LONG: if (!pb) begin
          state         <= IDLE;
          release_pulse <= 1'b1;
          held          <= 1'b0;
        end
        default: begin
          state <= LOCK;
          timer <= '0;
          held  <= 1'b0;
        end
      endcase
    end
  end
  assign bus.press_pulse   = press_pulse;
  assign bus.release_pulse = release_pulse;
  assign bus.click         = click;
  assign bus.double_click  = double_click;
  assign bus.long_press    = long_press;
  assign bus.held          = held;
  assign bus.evt_count     = evt_count;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_END = CNT_W'(REPEAT_TICKS - 1);
  logic [CNT_W-1:0] rep_timer;
  logic             repeat_pulse;
  // rep_timer idles at 0 outside LONG, so it is already cleared on entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rep_timer    <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= 1'b0;
      if (state == LONG && pb) begin
        rep_timer    <= rep_timer == REPEAT_END ? '0 : rep_timer + CNT_W'(1);
        repeat_pulse <= rep_timer == REPEAT_END;
      end else rep_timer <= '0;
    end
  end
  assign bus.repeat_pulse = repeat_pulse;
`else
  assign bus.repeat_pulse = 1'b0;
`endif
endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: directed gesture sequences with hand-computed per-cycle pulse patterns.
module tb_button_event_decoder;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   passed = 0;
  button_event_decoder_if bus ();
  button_event_decoder #(.LONG_TICKS(8), .DCLICK_TICKS(4), .REPEAT_TICKS(3), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );
  always #5 clk = ~clk;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [31:0] REP_4A = 32'h0000_0800;
  localparam logic [31:0] REP_6  = 32'h0000_4800;
`else
  localparam logic [31:0] REP_4A = 32'h0;
  localparam logic [31:0] REP_6  = 32'h0;
`endif
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask
  task automatic tick(input logic pb);
    bus.pb_level = pb;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] outs();
    return {25'd0, bus.press_pulse, bus.release_pulse, bus.click, bus.double_click,
            bus.long_press, bus.repeat_pulse, bus.held};
  endfunction
  task automatic seq(input string tag, input int n, input logic [31:0] pb,
                     input logic [31:0] p, r, c, d, l, rp, h);
    logic [31:0] op, orl, oc, od, ol, orp, oh;
    {op, orl, oc, od, ol, orp, oh} = '0;
    for (int i = 0; i < n; i++) begin
      tick(pb[i]);
      op[i]  = bus.press_pulse;
      orl[i] = bus.release_pulse;
      oc[i]  = bus.click;
      od[i]  = bus.double_click;
      ol[i]  = bus.long_press;
      orp[i] = bus.repeat_pulse;
      oh[i]  = bus.held;
    end
    check({tag, ".press"}, op, p);
    check({tag, ".release"}, orl, r);
    check({tag, ".click"}, oc, c);
    check({tag, ".dclick"}, od, d);
    check({tag, ".long"}, ol, l);
    check({tag, ".repeat"}, orp, rp);
    check({tag, ".held"}, oh, h);
  endtask
  initial begin
    rst_n = 1'b0;
    bus.pb_level = 1'b1;
    repeat (3) tick(1'b1);
    check("reset.outs", outs(), 32'h0);
    check("reset.count", {24'd0, bus.evt_count}, 32'd0);
    rst_n = 1'b1;
    seq("lock", 22, 32'h000F_FFFF, 0, 0, 0, 0, 0, 0, 0);
    check("lock.count", {24'd0, bus.evt_count}, 32'd0);
    seq("click", 10, 32'h7, 32'h1, 32'h8, 32'h80, 0, 0, 0, 32'h7);
    check("click.count", {24'd0, bus.evt_count}, 32'd1);
    seq("dclick", 14, 32'hE7, 32'h21, 32'h108, 0, 32'h100, 0, 0, 32'hE7);
    check("dclick.count", {24'd0, bus.evt_count}, 32'd2);
    seq("long", 18, 32'hFFF, 32'h1, 32'h1000, 0, 0, 32'h100, REP_4A, 32'hFFF);
    check("long.count", {24'd0, bus.evt_count}, 32'd2);
    seq("long_edge", 16, 32'hFF, 32'h1, 32'h100, 32'h1000, 0, 0, 0, 32'hFF);
    check("long_edge.count", {24'd0, bus.evt_count}, 32'd3);
    seq("win_edge", 16, 32'h387, 32'h81, 32'h408, 0, 32'h400, 0, 0, 32'h387);
    check("win_edge.count", {24'd0, bus.evt_count}, 32'd4);
    seq("repeat", 22, 32'hFFFF, 32'h1, 32'h10000, 0, 0, 32'h100, REP_6, 32'hFFFF);
    check("repeat.count", {24'd0, bus.evt_count}, 32'd4);
    tick(1'b1);
    tick(1'b0);
    rst_n = 1'b0;
    tick(1'b0);
    check("abort.outs", outs(), 32'h0);
    rst_n = 1'b1;
    seq("abort", 8, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    check("abort.count", {24'd0, bus.evt_count}, 32'd0);
    for (int i = 0; i < 255; i++) begin
      tick(1'b1);
      repeat (6) tick(1'b0);
    end
    check("preload.count", {24'd0, bus.evt_count}, 32'd255);
    seq("wrap", 8, 32'h1, 32'h1, 32'h2, 32'h20, 0, 0, 0, 32'h1);
    check("wrap.count", {24'd0, bus.evt_count}, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
